// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and RAM signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage and a debug port.
// Defining DMEM_ARB_STARVE_EN adds a guard that forces debug to win after STARVE_LIMIT losses.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_e;

    state_e        state_q, state_d;
    logic          cpu_elig, cpu_win, dbg_win, force_dbg;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

`ifdef DMEM_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = (!bus.dbg_req || dbg_win) ? '0 :
                   (starve_q == LIM) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    assign force_dbg = starve_q == LIM;
`else
    assign force_dbg = STARVE_LIMIT < 0;
`endif

    // The load completing in CPU_RD is the same held request, so it is never reissued.
    always_comb begin
        cpu_elig  = bus.cpu_req && state_q != CPU_RD;
        dbg_win   = bus.dbg_req && (!cpu_elig || force_dbg);
        cpu_win   = cpu_elig && !dbg_win;
        state_d   = (cpu_win && !bus.cpu_we) ? CPU_RD :
                    (dbg_win && !bus.dbg_we) ? DBG_RD : IDLE;
        addr_sel  = cpu_win ? bus.cpu_addr  : dbg_win ? bus.dbg_addr  : '0;
        wdata_sel = cpu_win ? bus.cpu_wdata : dbg_win ? bus.dbg_wdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Every output is held at 0 while reset is low, even the combinational stall.
    always_comb begin
        bus.mem_en     = reset && (cpu_win || dbg_win);
        bus.mem_we     = reset && (cpu_win ? bus.cpu_we : dbg_win && bus.dbg_we);
        bus.mem_addr   = reset ? addr_sel : '0;
        bus.mem_wdata  = reset ? wdata_sel : '0;
        bus.cpu_stall  = reset && cpu_elig && (!cpu_win || !bus.cpu_we);
        bus.dbg_gnt    = reset && dbg_win;
        bus.dbg_rvalid = reset && state_q == DBG_RD;
        bus.cpu_rdata  = (reset && state_q == CPU_RD) ? bus.mem_rdata : '0;
        bus.dbg_rdata  = (reset && state_q == DBG_RD) ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with queued expectations checked by a negedge monitor.
// A behavioural synchronous RAM answers the arbiter's memory port.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [31:0] ram [0:63];
    logic [31:0] cpu_q [$];
    logic [31:0] dbg_q [$];
    logic [31:0] gnt_q [$];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a CPU load completes when it is held and no longer stalled.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.dbg_rvalid) begin
                if (dbg_q.size() == 0) chk("spurious dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
                else chk("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
            end
            if (bus.dbg_gnt) begin
                if (gnt_q.size() == 0) chk("spurious dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
                else chk("dbg_gnt mem_addr", bus.mem_addr, gnt_q.pop_front());
            end
            if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall) begin
                if (cpu_q.size() == 0) chk("spurious cpu load", 32'(bus.cpu_stall), 32'd1);
                else chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic g;
        logic exp_gnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        @(negedge clk);
        chk("reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("reset dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("reset mem_en", 32'(bus.mem_en), 32'd0);
        chk("reset dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        cyc();
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle mem_en", 32'(bus.mem_en), 32'd0);
            cyc();
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("store mem_en", 32'(bus.mem_en), 32'd1);
        chk("store mem_we", 32'(bus.mem_we), 32'd1);
        chk("store mem_addr", bus.mem_addr, 32'h10);
        chk("store mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("store cpu_stall", 32'(bus.cpu_stall), 32'd0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            bus.cpu_we = 1'b0;
            cpu_q.push_back(32'hDEADBEEF);
            @(negedge clk);
            chk("load issue cpu_stall", 32'(bus.cpu_stall), 32'd1);
            chk("load issue mem_en", 32'(bus.mem_en), 32'd1);
            chk("load issue mem_we", 32'(bus.mem_we), 32'd0);
            cyc();
            @(negedge clk);
            chk("load done cpu_stall", 32'(bus.cpu_stall), 32'd0);
            cyc();
        end
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h12345678;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
        gnt_q.push_back(32'h20);
        dbg_q.push_back(32'h12345678);
        @(negedge clk);
        chk("collide dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("collide mem_addr", bus.mem_addr, 32'h20);
        chk("collide mem_we", 32'(bus.mem_we), 32'd1);
        chk("collide cpu_stall", 32'(bus.cpu_stall), 32'd0);
        cyc();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("collide late dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("collide late mem_we", 32'(bus.mem_we), 32'd0);
        cyc();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("collide dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h55;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h44; bus.dbg_wdata = 32'hA5A5;
`ifdef DMEM_ARB_STARVE_EN
        gnt_q.push_back(32'h44);
`endif
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_STARVE_EN
            exp_gnt = i == 4;
`else
            exp_gnt = 1'b0;
`endif
            @(negedge clk);
            chk($sformatf("starve dbg_gnt c%0d", i + 1), 32'(bus.dbg_gnt), 32'(exp_gnt));
            chk($sformatf("starve cpu_stall c%0d", i + 1), 32'(bus.cpu_stall), 32'(exp_gnt));
            g = bus.dbg_gnt;
            cyc();
            if (g) bus.dbg_req = 1'b0;
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        cyc();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
        gnt_q.push_back(32'h20);
        @(negedge clk);
        chk("rst-read dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        cyc();
        bus.dbg_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst-read dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post-rst dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
            chk("post-rst mem_en", 32'(bus.mem_en), 32'd0);
            cyc();
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        cpu_q.push_back(32'h12345678);
        @(negedge clk);
        chk("post-rst load cpu_stall", 32'(bus.cpu_stall), 32'd1);
        cyc();
        @(negedge clk);
        chk("post-rst load done cpu_stall", 32'(bus.cpu_stall), 32'd0);
        cyc();
        bus.cpu_req = 1'b0;
        cyc();
        chk("cpu_q drained", 32'(cpu_q.size()), 32'd0);
        chk("dbg_q drained", 32'(dbg_q.size()), 32'd0);
        chk("gnt_q drained", 32'(gnt_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
